// File: rtl/fsm_counter_param_pkg.sv
// Shared definitions for the parametrised counter-FSM: terminal-mode encodings
// and a range clamp helper.
package fsm_counter_param_pkg;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_LOOP = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  // Limit v to the closed range [lo, hi].
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/fsm_dff.sv
// Width-parametrised D flip-flop with asynchronous active-high reset to RST_VAL.
module fsm_dff #(
  parameter int unsigned W                 = 1,
  parameter logic [W-1:0] RST_VAL          = '0
) (
  input  logic         clk,
  input  logic         Re,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge Re) begin
    if (Re) q <= RST_VAL;
    else    q <= d;
  end

endmodule

// File: rtl/fsm_next_state.sv
// Combinational next-count, terminal-pulse and sticky-flag logic for the
// counter-FSM. Bounds are checked before stepping, so no native overflow occurs.
module fsm_next_state
  import fsm_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int          MIN     = 0,
  parameter int          MAX     = 7,
  parameter int          LOOP_LO = 5
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             ovf_i,
  input  logic             en_i,
  input  logic             w_i,
  input  logic [1:0]       mode_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  output logic [WIDTH-1:0] q_d_c,
  output logic             z_d_c,
  output logic             ovf_d_c
);

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LOOP_V = WIDTH'(LOOP_LO);

  // Signed 32-bit views keep the range compares free of constant-result warnings.
  int q_int;
  int ld_int;
  assign q_int  = int'(q_i);
  assign ld_int = int'(ld_val_i);

  always_comb begin
    q_d_c   = q_i;
    z_d_c   = 1'b0;
    ovf_d_c = ovf_i;
    if (ld_i) begin
      q_d_c   = WIDTH'(clamp_int(ld_int, MIN, MAX));
      ovf_d_c = 1'b0;
    end else if (en_i && (mode_i != MODE_HOLD)) begin
      if ((q_int < MIN) || (q_int > MAX)) begin
        q_d_c = MIN_V;
      end else if (w_i) begin
        if (q_int < MAX) begin
          q_d_c = q_i + WIDTH'(1);
        end else begin
          z_d_c   = 1'b1;
          ovf_d_c = 1'b1;
          case (mode_i)
            MODE_WRAP: q_d_c = MIN_V;
            MODE_LOOP: q_d_c = LOOP_V;
            default:   q_d_c = MAX_V;
          endcase
        end
      end else begin
        if (q_int > MIN) begin
          q_d_c = q_i - WIDTH'(1);
        end else begin
          z_d_c   = 1'b1;
          ovf_d_c = 1'b1;
          q_d_c   = (mode_i == MODE_WRAP) ? MAX_V : MIN_V;
        end
      end
    end
  end

endmodule

// File: rtl/fsm_counter_param.sv
// Registered, range-configurable counter-FSM with direction, load, enable and
// run-time terminal mode (wrap / saturate / loop-back / hold).
module fsm_counter_param
  import fsm_counter_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 3,
  parameter int          MIN     = 0,
  parameter int          MAX     = 7,
  parameter int          LOOP_LO = 5
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] q,
  output logic             z,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;
  logic             ovf_q, ovf_d;

  // Next-state logic.
  fsm_next_state #(
    .WIDTH   (WIDTH),
    .MIN     (MIN),
    .MAX     (MAX),
    .LOOP_LO (LOOP_LO)
  ) u_next (
    .q_i      (cnt_q),
    .ovf_i    (ovf_q),
    .en_i     (en),
    .w_i      (w),
    .mode_i   (mode),
    .ld_i     (ld),
    .ld_val_i (ld_val),
    .q_d_c    (cnt_d),
    .z_d_c    (z_d),
    .ovf_d_c  (ovf_d)
  );

  // State and flag registers.
  fsm_dff #(.W(WIDTH), .RST_VAL(WIDTH'(MIN))) u_cnt (
    .clk (clk), .Re (Re), .d (cnt_d), .q (cnt_q)
  );
  fsm_dff #(.W(1), .RST_VAL(1'b0)) u_z (
    .clk (clk), .Re (Re), .d (z_d), .q (z_q)
  );
  fsm_dff #(.W(1), .RST_VAL(1'b0)) u_ovf (
    .clk (clk), .Re (Re), .d (ovf_d), .q (ovf_q)
  );

  // Outputs come straight from the flops.
  always_comb begin
    q   = cnt_q;
    z   = z_q;
    ovf = ovf_q;
  end

endmodule

// File: tb/tb_fsm_counter_param.sv
// Self-checking bench for fsm_counter_param: directed vector table on the default
// configuration plus hand sequences for async reset and a WIDTH=4, MAX=9 instance.
module tb_fsm_counter_param;
  import fsm_counter_param_pkg::*;

  typedef struct packed {
    logic       ld;
    logic       en;
    logic       w;
    logic [1:0] mode;
    logic [2:0] ld_val;
    logic [2:0] exp_q;
    logic       exp_z;
    logic       exp_ovf;
  } vec_t;

  logic       clk, Re;
  logic       en, w, ld;
  logic [1:0] mode;
  logic [2:0] ld_val, q;
  logic       z, ovf;

  logic       en2, w2, ld2;
  logic [1:0] mode2;
  logic [3:0] ld_val2, q2;
  logic       z2, ovf2;

  int checks = 0;
  int errors = 0;

  fsm_counter_param dut (
    .clk(clk), .Re(Re), .en(en), .w(w), .mode(mode), .ld(ld),
    .ld_val(ld_val), .q(q), .z(z), .ovf(ovf)
  );

  fsm_counter_param #(.WIDTH(4), .MIN(0), .MAX(9), .LOOP_LO(5)) dut2 (
    .clk(clk), .Re(Re), .en(en2), .w(w2), .mode(mode2), .ld(ld2),
    .ld_val(ld_val2), .q(q2), .z(z2), .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input logic [2:0] eq, input logic ez, input logic eo);
    chk({name, " q"},   32'(q),   32'(eq));
    chk({name, " z"},   32'(z),   32'(ez));
    chk({name, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  task automatic drive(input logic l, input logic e, input logic d, input logic [1:0] m,
                       input logic [2:0] v);
    ld = l; en = e; w = d; mode = m; ld_val = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Re = 1'b1;
    step();
    chk3("reset", 3'd0, 1'b0, 1'b0);
    #2;
    Re = 1'b0;
  endtask

  function automatic vec_t mk(input logic l, input logic e, input logic d, input logic [1:0] m,
                              input logic [2:0] v, input logic [2:0] eq, input logic ez,
                              input logic eo);
    vec_t r;
    r = '{ld: l, en: e, w: d, mode: m, ld_val: v, exp_q: eq, exp_z: ez, exp_ovf: eo};
    return r;
  endfunction

  vec_t vecs [37];

  initial begin
    Re = 1'b1;
    drive(1'b0, 1'b0, 1'b0, MODE_WRAP, 3'd0);
    en2 = 1'b0; w2 = 1'b0; ld2 = 1'b0; mode2 = MODE_WRAP; ld_val2 = 4'd0;

    // Legacy LOOP sequence from reset.
    vecs[0]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd1, 0, 0);
    vecs[1]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd2, 0, 0);
    vecs[2]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd3, 0, 0);
    vecs[3]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd4, 0, 0);
    vecs[4]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd5, 0, 0);
    vecs[5]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd6, 0, 0);
    vecs[6]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd7, 0, 0);
    vecs[7]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd5, 1, 1);
    vecs[8]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd6, 0, 1);
    vecs[9]  = mk(0, 1, 1, MODE_LOOP, 0, 3'd7, 0, 1);
    // Load 3 clears ovf, then HOLD and en=0 keep it.
    vecs[10] = mk(1, 0, 1, MODE_WRAP, 3, 3'd3, 0, 0);
    vecs[11] = mk(0, 1, 1, MODE_HOLD, 0, 3'd3, 0, 0);
    vecs[12] = mk(0, 1, 1, MODE_HOLD, 0, 3'd3, 0, 0);
    vecs[13] = mk(0, 1, 1, MODE_HOLD, 0, 3'd3, 0, 0);
    vecs[14] = mk(0, 0, 1, MODE_WRAP, 0, 3'd3, 0, 0);
    vecs[15] = mk(0, 0, 1, MODE_WRAP, 0, 3'd3, 0, 0);
    // Load beats enable.
    vecs[16] = mk(1, 1, 1, MODE_WRAP, 2, 3'd2, 0, 0);
    // WRAP down through MIN.
    vecs[17] = mk(1, 0, 0, MODE_WRAP, 0, 3'd0, 0, 0);
    vecs[18] = mk(0, 1, 0, MODE_WRAP, 0, 3'd7, 1, 1);
    vecs[19] = mk(0, 1, 0, MODE_WRAP, 0, 3'd6, 0, 1);
    vecs[20] = mk(0, 1, 0, MODE_WRAP, 0, 3'd5, 0, 1);
    // SAT up from 6: repeated terminal events keep z high.
    vecs[21] = mk(1, 0, 1, MODE_SAT,  6, 3'd6, 0, 0);
    vecs[22] = mk(0, 1, 1, MODE_SAT,  0, 3'd7, 0, 0);
    vecs[23] = mk(0, 1, 1, MODE_SAT,  0, 3'd7, 1, 1);
    vecs[24] = mk(0, 1, 1, MODE_SAT,  0, 3'd7, 1, 1);
    vecs[25] = mk(1, 0, 1, MODE_SAT,  3, 3'd3, 0, 0);
    // LOOP down holds at MIN, each step is terminal.
    vecs[26] = mk(1, 0, 0, MODE_LOOP, 0, 3'd0, 0, 0);
    vecs[27] = mk(0, 1, 0, MODE_LOOP, 0, 3'd0, 1, 1);
    vecs[28] = mk(0, 1, 0, MODE_LOOP, 0, 3'd0, 1, 1);
    vecs[29] = mk(0, 1, 1, MODE_LOOP, 0, 3'd1, 0, 1);
    // SAT down to MIN.
    vecs[30] = mk(1, 0, 0, MODE_SAT,  1, 3'd1, 0, 0);
    vecs[31] = mk(0, 1, 0, MODE_SAT,  0, 3'd0, 0, 0);
    vecs[32] = mk(0, 1, 0, MODE_SAT,  0, 3'd0, 1, 1);
    // WRAP up at MAX, then idle keeps ovf and drops z.
    vecs[33] = mk(1, 0, 1, MODE_WRAP, 7, 3'd7, 0, 0);
    vecs[34] = mk(0, 1, 1, MODE_WRAP, 0, 3'd0, 1, 1);
    vecs[35] = mk(0, 0, 1, MODE_WRAP, 0, 3'd0, 0, 1);
    vecs[36] = mk(0, 1, 0, MODE_HOLD, 0, 3'd0, 0, 1);

    do_reset();
    chk("reset q2", 32'(q2), 32'd0);

    for (int i = 0; i < 37; i++) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].w, vecs[i].mode, vecs[i].ld_val);
      step();
      chk3($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_z, vecs[i].exp_ovf);
    end

    // WRAP down from reset, then async reset mid-count at q=4.
    drive(1'b0, 1'b0, 1'b0, MODE_WRAP, 3'd0);
    do_reset();
    drive(1'b0, 1'b1, 1'b0, MODE_WRAP, 3'd0);
    step(); chk3("wrapdn 1", 3'd7, 1'b1, 1'b1);
    step(); chk3("wrapdn 2", 3'd6, 1'b0, 1'b1);
    step(); chk3("wrapdn 3", 3'd5, 1'b0, 1'b1);
    step(); chk3("wrapdn 4", 3'd4, 1'b0, 1'b1);
    #2;
    Re = 1'b1;
    #1;
    chk3("async rst", 3'd0, 1'b0, 1'b0);
    Re = 1'b0;
    drive(1'b0, 1'b1, 1'b1, MODE_LOOP, 3'd0);
    #1;
    chk3("rst low idle", 3'd0, 1'b0, 1'b0);
    step(); chk3("resume", 3'd1, 1'b0, 1'b0);

    // WIDTH=4, MAX=9 instance: load clamps, WRAP up from MAX.
    drive(1'b0, 1'b0, 1'b1, MODE_WRAP, 3'd0);
    ld2 = 1'b1; en2 = 1'b0; w2 = 1'b1; mode2 = MODE_WRAP; ld_val2 = 4'd14;
    step();
    chk("w4 clamp q", 32'(q2), 32'd9);
    chk("w4 clamp ovf", 32'(ovf2), 32'd0);
    ld2 = 1'b0; en2 = 1'b1;
    step();
    chk("w4 wrap q", 32'(q2), 32'd0);
    chk("w4 wrap z", 32'(z2), 32'd1);
    chk("w4 wrap ovf", 32'(ovf2), 32'd1);
    ld2 = 1'b1; en2 = 1'b1; ld_val2 = 4'd8;
    step();
    chk("w4 ld in range q", 32'(q2), 32'd8);
    chk("w4 ld ovf", 32'(ovf2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
